// File: rtl/mem_access_unit.sv
// Memory-access stage: runs the dmem req/ack handshake, aligns store lanes
// and extends load data, delivering one write-back beat per instruction.
module mem_access_unit #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] ex_rs2_data,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [1:0]  wb_exc
);

    localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [1:0]    off_q;
    logic [2:0]    f3_q;
    logic [4:0]    rd_q;
    logic          rw_q;

    logic          is_mem;
    logic          is_load;
    logic          legal;
    logic          misal;
    logic          timeout;
    logic [3:0]    be_d;
    logic [31:0]   wdata_d;
    logic [31:0]   shifted;
    logic [15:0]   half;
    logic [31:0]   load_data;

    assign ex_ready = (state_q == IDLE);
    assign is_mem   = ex_mem_read | ex_mem_write;
    // A read-and-write instruction is handled as a load.
    assign is_load  = ex_mem_read;
    assign cnt_d    = cnt_q + 1'b1;
    assign timeout  = (ACK_TIMEOUT != 0) && (cnt_d == CW'(ACK_TIMEOUT));

    always_comb begin
        legal = 1'b0;
        case (ex_funct3)
            3'd0, 3'd1, 3'd2: legal = 1'b1;
            3'd4, 3'd5:       legal = is_load;
            default:          legal = 1'b0;
        endcase
        misal = ((ex_funct3[1:0] == 2'd1) && ex_alu_out[0]) ||
                ((ex_funct3[1:0] == 2'd2) && (ex_alu_out[1:0] != 2'b00));
    end

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = ex_rs2_data;
        if (!is_load) begin
            case (ex_funct3[1:0])
                2'd0: begin
                    be_d    = 4'b0001 << ex_alu_out[1:0];
                    wdata_d = {4{ex_rs2_data[7:0]}};
                end
                2'd1: begin
                    be_d    = ex_alu_out[1] ? 4'b1100 : 4'b0011;
                    wdata_d = {2{ex_rs2_data[15:0]}};
                end
                default: begin
                    be_d    = 4'b1111;
                    wdata_d = ex_rs2_data;
                end
            endcase
        end
    end

    always_comb begin
        shifted = dmem_rdata >> {off_q, 3'b000};
        half    = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (f3_q)
            3'd0:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'd4:    load_data = {24'd0, shifted[7:0]};
            3'd1:    load_data = {{16{half[15]}}, half};
            3'd5:    load_data = {16'd0, half};
            default: load_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            off_q        <= '0;
            f3_q         <= '0;
            rd_q         <= '0;
            rw_q         <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= '0;
            dmem_wdata   <= '0;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            wb_exc       <= '0;
        end else begin
            wb_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ex_valid) begin
                        cnt_q <= '0;
                        if (!is_mem) begin
                            wb_valid     <= 1'b1;
                            wb_data      <= ex_alu_out;
                            wb_rd        <= ex_rd;
                            wb_reg_write <= ex_reg_write;
                            wb_exc       <= 2'd0;
                        end else if (!legal || misal) begin
                            wb_valid     <= 1'b1;
                            wb_data      <= ex_alu_out;
                            wb_rd        <= ex_rd;
                            wb_reg_write <= 1'b0;
                            wb_exc       <= legal ? 2'd1 : 2'd3;
                        end else begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= ~is_load;
                            dmem_addr  <= {ex_alu_out[31:2], 2'b00};
                            dmem_be    <= be_d;
                            dmem_wdata <= wdata_d;
                            off_q      <= ex_alu_out[1:0];
                            f3_q       <= ex_funct3;
                            rd_q       <= ex_rd;
                            rw_q       <= ex_reg_write;
                            state_q    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Ack is checked first so an ack on the limit cycle wins.
                    if (dmem_ack) begin
                        dmem_req     <= 1'b0;
                        state_q      <= IDLE;
                        wb_valid     <= 1'b1;
                        wb_rd        <= rd_q;
                        wb_exc       <= 2'd0;
                        wb_data      <= dmem_we ? 32'd0 : load_data;
                        wb_reg_write <= dmem_we ? 1'b0 : rw_q;
                    end else if (timeout) begin
                        dmem_req     <= 1'b0;
                        state_q      <= IDLE;
                        wb_valid     <= 1'b1;
                        wb_rd        <= rd_q;
                        wb_exc       <= 2'd2;
                        wb_reg_write <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
